// File: rtl/maxi_rd_arbiter_if.sv
// maxi_rd_arbiter_if: one burst-read channel (AR request + R beats), valid carried in the bus MSB.
// The master modport issues requests; the slave modport accepts them and returns beats.
interface maxi_rd_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64);
  logic [ADDR_W:0] ARADDR;
  logic [3:0] ARLEN;
  logic ARADDR_ready;
  logic [DATA_W:0] RDATA;
  logic RLAST;
  logic [1:0] RRESP;
  logic RDATA_ready;
  modport master (output ARADDR, ARLEN, RDATA_ready, input ARADDR_ready, RDATA, RLAST, RRESP);
  modport slave (input ARADDR, ARLEN, RDATA_ready, output ARADDR_ready, RDATA, RLAST, RRESP);
endinterface

// File: rtl/maxi_rd_arbiter.sv
// maxi_rd_arbiter: round-robin share of one MAXI read port between two burst readers.
// Owners of accepted bursts are queued in order; R beats are steered to the head owner until RLAST.
module maxi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int OUTST = 4
) (
  input  logic CLK,
  input  logic reset,
  maxi_rd_arbiter_if.slave r0,
  maxi_rd_arbiter_if.slave r1,
  maxi_rd_arbiter_if.master m,
  output logic [1:0] M_ARSIZE,
  output logic [1:0] M_ARBURST,
  output logic [$clog2(OUTST):0] outstanding,
  output logic err_orphan
);
  localparam int PW = $clog2(OUTST);
  logic ar_v_q, ar_v_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [3:0] ar_len_q, ar_len_d;
  logic rr_last_q, rr_last_d;
  logic [OUTST-1:0] own_q, own_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic v0, v1, gnt, gnt_idx, ne, h, mv, rdy, pop;
  always_comb begin
    v0 = r0.ARADDR[ADDR_W];
    v1 = r1.ARADDR[ADDR_W];
    gnt_idx = (v0 && v1) ? !rr_last_q : v1;
    // a pop in this cycle does not free a slot until the count register updates
    gnt = !reset && (v0 || v1) && (!ar_v_q || m.ARADDR_ready) && cnt_q < (PW+1)'(OUTST);
    ne = cnt_q != '0;
    h = own_q[rp_q];
    mv = m.RDATA[DATA_W];
    rdy = ne && (h ? r1.RDATA_ready : r0.RDATA_ready);
    pop = mv && rdy && m.RLAST;
    ar_v_d = gnt || (ar_v_q && !m.ARADDR_ready);
    ar_addr_d = gnt ? (gnt_idx ? r1.ARADDR[ADDR_W-1:0] : r0.ARADDR[ADDR_W-1:0]) : ar_addr_q;
    ar_len_d = gnt ? (gnt_idx ? r1.ARLEN : r0.ARLEN) : ar_len_q;
    rr_last_d = gnt ? gnt_idx : rr_last_q;
    own_d = own_q;
    own_d[wp_q] = gnt ? gnt_idx : own_q[wp_q];
    wp_d = wp_q + PW'(gnt);
    rp_d = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(gnt) - (PW+1)'(pop);
    err_d = err_q || (mv && !ne);
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      ar_v_q <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q <= '0;
      rr_last_q <= 1'b1;
      own_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ar_v_q <= ar_v_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q <= ar_len_d;
      rr_last_q <= rr_last_d;
      own_q <= own_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign r0.ARADDR_ready = gnt && !gnt_idx;
  assign r1.ARADDR_ready = gnt && gnt_idx;
  assign r0.RDATA = (ne && !h) ? m.RDATA : '0;
  assign r1.RDATA = (ne && h) ? m.RDATA : '0;
  assign r0.RLAST = ne && !h && m.RLAST;
  assign r1.RLAST = ne && h && m.RLAST;
  assign r0.RRESP = (ne && !h) ? m.RRESP : 2'b00;
  assign r1.RRESP = (ne && h) ? m.RRESP : 2'b00;
  assign m.ARADDR = {ar_v_q, ar_addr_q};
  assign m.ARLEN = ar_len_q;
  assign m.RDATA_ready = rdy;
  assign M_ARSIZE = 2'b11;
  assign M_ARBURST = 2'b01;
  assign outstanding = cnt_q;
  assign err_orphan = err_q;
endmodule

// File: tb/tb_maxi_rd_arbiter.sv
// tb_maxi_rd_arbiter: directed scenarios for the two-requester MAXI read arbiter.
module tb_maxi_rd_arbiter;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic [1:0] M_ARSIZE, M_ARBURST;
  logic [2:0] outstanding;
  logic err_orphan;
  int checks = 0;
  int errors = 0;
  maxi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) r0_if();
  maxi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) r1_if();
  maxi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) m_if();
  maxi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .OUTST(4)) dut (
    .CLK(CLK), .reset(reset), .r0(r0_if), .r1(r1_if), .m(m_if),
    .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .outstanding(outstanding), .err_orphan(err_orphan)
  );
  always #5 CLK = ~CLK;
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end
  task automatic idle();
    r0_if.ARADDR = '0; r0_if.ARLEN = '0; r0_if.RDATA_ready = 1'b0;
    r1_if.ARADDR = '0; r1_if.ARLEN = '0; r1_if.RDATA_ready = 1'b0;
    m_if.ARADDR_ready = 1'b0; m_if.RDATA = '0; m_if.RLAST = 1'b0; m_if.RRESP = 2'b00;
  endtask
  task automatic do_reset();
    idle();
    @(negedge CLK) reset = 1'b1;
    @(negedge CLK) reset = 1'b0;
  endtask
  task automatic test_reset();
    idle();
    #1 reset = 1'b1;
    r0_if.ARADDR = {1'b1, 32'h10};
    m_if.ARADDR_ready = 1'b1;
    @(negedge CLK); #1;
    checks++; if (m_if.ARADDR !== 33'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", m_if.ARADDR); end
    checks++; if (m_if.ARLEN !== 4'h0) begin errors++; $display("FAIL reset_arlen got %h exp 0", m_if.ARLEN); end
    checks++; if (r0_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready got %b exp 0", r0_if.ARADDR_ready); end
    checks++; if (m_if.RDATA_ready !== 1'b0) begin errors++; $display("FAIL reset_m_rready got %b exp 0", m_if.RDATA_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_orphan); end
    checks++; if (r0_if.RDATA[64] !== 1'b0) begin errors++; $display("FAIL reset_r0_valid got %b exp 0", r0_if.RDATA[64]); end
    idle();
    @(negedge CLK) reset = 1'b0;
  endtask
  task automatic test_single();
    do_reset();
    r0_if.ARADDR = {1'b1, 32'h1000}; r0_if.ARLEN = 4'd3; m_if.ARADDR_ready = 1'b1;
    #1;
    checks++; if (r0_if.ARADDR_ready !== 1'b1) begin errors++; $display("FAIL single_r0_ready got %b exp 1", r0_if.ARADDR_ready); end
    checks++; if (r1_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL single_r1_ready got %b exp 0", r1_if.ARADDR_ready); end
    @(negedge CLK);
    r0_if.ARADDR = '0;
    #1;
    checks++; if (m_if.ARADDR !== 33'h1_0000_1000) begin errors++; $display("FAIL single_araddr got %h exp 100001000", m_if.ARADDR); end
    checks++; if (m_if.ARLEN !== 4'd3) begin errors++; $display("FAIL single_arlen got %0d exp 3", m_if.ARLEN); end
    checks++; if (M_ARSIZE !== 2'b11) begin errors++; $display("FAIL single_arsize got %b exp 11", M_ARSIZE); end
    checks++; if (M_ARBURST !== 2'b01) begin errors++; $display("FAIL single_arburst got %b exp 01", M_ARBURST); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
    @(negedge CLK); #1;
    checks++; if (m_if.ARADDR[32] !== 1'b0) begin errors++; $display("FAIL single_ar_clear got %b exp 0", m_if.ARADDR[32]); end
  endtask
  task automatic test_ar_stall();
    do_reset();
    r1_if.ARADDR = {1'b1, 32'h2000}; r1_if.ARLEN = 4'd7;
    #1;
    checks++; if (r1_if.ARADDR_ready !== 1'b1) begin errors++; $display("FAIL stall_first_grant got %b exp 1", r1_if.ARADDR_ready); end
    @(negedge CLK); #1;
    checks++; if (m_if.ARADDR !== 33'h1_0000_2000) begin errors++; $display("FAIL stall_araddr got %h exp 100002000", m_if.ARADDR); end
    checks++; if (r1_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL stall_blocked got %b exp 0", r1_if.ARADDR_ready); end
    m_if.ARADDR_ready = 1'b1;
    #1;
    checks++; if (r1_if.ARADDR_ready !== 1'b1) begin errors++; $display("FAIL stall_released got %b exp 1", r1_if.ARADDR_ready); end
    @(negedge CLK);
    idle();
    #1;
    checks++; if (m_if.ARLEN !== 4'd7) begin errors++; $display("FAIL stall_arlen got %0d exp 7", m_if.ARLEN); end
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL stall_outstanding got %0d exp 2", outstanding); end
  endtask
  task automatic test_rr_fill();
    logic [32:0] prev;
    do_reset();
    r0_if.ARADDR = {1'b1, 32'h100}; r0_if.ARLEN = 4'd1;
    r1_if.ARADDR = {1'b1, 32'h200}; r1_if.ARLEN = 4'd2;
    m_if.ARADDR_ready = 1'b1;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (r0_if.ARADDR_ready !== (i % 2 == 0)) begin errors++; $display("FAIL rr_r0_ready[%0d] got %b exp %b", i, r0_if.ARADDR_ready, i % 2 == 0); end
      checks++; if (r1_if.ARADDR_ready !== (i % 2 == 1)) begin errors++; $display("FAIL rr_r1_ready[%0d] got %b exp %b", i, r1_if.ARADDR_ready, i % 2 == 1); end
      if (i > 0) begin
        checks++; if (m_if.ARADDR !== prev) begin errors++; $display("FAIL rr_araddr[%0d] got %h exp %h", i, m_if.ARADDR, prev); end
      end
      prev = (i % 2 == 0) ? 33'h1_0000_0100 : 33'h1_0000_0200;
      @(negedge CLK);
    end
    #1;
    checks++; if (r0_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL rr_full_r0 got %b exp 0", r0_if.ARADDR_ready); end
    checks++; if (r1_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL rr_full_r1 got %b exp 0", r1_if.ARADDR_ready); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL rr_full_outstanding got %0d exp 4", outstanding); end
    checks++; if (m_if.ARADDR !== 33'h1_0000_0200 || m_if.ARLEN !== 4'd2) begin errors++; $display("FAIL rr_last_ar got %h/%0d exp 100000200/2", m_if.ARADDR, m_if.ARLEN); end
    idle();
    @(negedge CLK);
  endtask
  task automatic test_r_steer();
    logic [64:0] d;
    r0_if.RDATA_ready = 1'b1; r1_if.RDATA_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) begin
        d = {1'b1, 64'hA0 + 64'(b * 16 + j)};
        m_if.RDATA = d; m_if.RLAST = (j == 3); m_if.RRESP = (b == 1) ? 2'b10 : 2'b00;
        #1;
        checks++; if ((b == 1 ? r1_if.RDATA : r0_if.RDATA) !== d) begin errors++; $display("FAIL steer_owner_data[%0d.%0d] got %h exp %h", b, j, b == 1 ? r1_if.RDATA : r0_if.RDATA, d); end
        checks++; if ((b == 1 ? r0_if.RDATA[64] : r1_if.RDATA[64]) !== 1'b0) begin errors++; $display("FAIL steer_other_valid[%0d.%0d] got 1 exp 0", b, j); end
        checks++; if ((b == 1 ? r1_if.RLAST : r0_if.RLAST) !== (j == 3)) begin errors++; $display("FAIL steer_rlast[%0d.%0d] got %b exp %b", b, j, b == 1 ? r1_if.RLAST : r0_if.RLAST, j == 3); end
        checks++; if (m_if.RDATA_ready !== 1'b1) begin errors++; $display("FAIL steer_m_ready[%0d.%0d] got %b exp 1", b, j, m_if.RDATA_ready); end
        if (b == 1) begin
          checks++; if (r1_if.RRESP !== 2'b10 || r0_if.RRESP !== 2'b00) begin errors++; $display("FAIL steer_rresp[%0d] got %b/%b exp 00/10", j, r0_if.RRESP, r1_if.RRESP); end
        end
        @(negedge CLK);
      end
      m_if.RDATA = '0; m_if.RLAST = 1'b0;
      #1;
      checks++; if (outstanding !== 3'(3 - b)) begin errors++; $display("FAIL steer_outstanding[%0d] got %0d exp %0d", b, outstanding, 3 - b); end
    end
    r0_if.RDATA_ready = 1'b0;
    m_if.RDATA = {1'b1, 64'hBEEF}; m_if.RLAST = 1'b1;
    #1;
    checks++; if (m_if.RDATA_ready !== 1'b0) begin errors++; $display("FAIL bp_m_ready_low got %b exp 0", m_if.RDATA_ready); end
    checks++; if (r0_if.RDATA !== {1'b1, 64'hBEEF}) begin errors++; $display("FAIL bp_data_held got %h exp 1000000000000beef", r0_if.RDATA); end
    @(negedge CLK); #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL bp_no_pop got %0d exp 2", outstanding); end
    r0_if.RDATA_ready = 1'b1;
    #1;
    checks++; if (m_if.RDATA_ready !== 1'b1) begin errors++; $display("FAIL bp_m_ready_high got %b exp 1", m_if.RDATA_ready); end
    @(negedge CLK);
    idle();
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL bp_pop got %0d exp 1", outstanding); end
  endtask
  task automatic test_full_pop_push();
    do_reset();
    r0_if.ARADDR = {1'b1, 32'h3000}; m_if.ARADDR_ready = 1'b1; r0_if.RDATA_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (r0_if.ARADDR_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d] got %b exp 1", i, r0_if.ARADDR_ready); end
      @(negedge CLK);
    end
    m_if.RDATA = {1'b1, 64'h77}; m_if.RLAST = 1'b1;
    #1;
    checks++; if (r0_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_grant got %b exp 0", r0_if.ARADDR_ready); end
    checks++; if (m_if.RDATA_ready !== 1'b1) begin errors++; $display("FAIL full_pop_rready got %b exp 1", m_if.RDATA_ready); end
    @(negedge CLK);
    m_if.RDATA = '0; m_if.RLAST = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_after_pop got %0d exp 3", outstanding); end
    checks++; if (r0_if.ARADDR_ready !== 1'b1) begin errors++; $display("FAIL full_next_grant got %b exp 1", r0_if.ARADDR_ready); end
    @(negedge CLK);
    idle();
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill got %0d exp 4", outstanding); end
  endtask
  task automatic test_orphan_reset();
    do_reset();
    m_if.RDATA = {1'b1, 64'h55};
    #1;
    checks++; if (m_if.RDATA_ready !== 1'b0) begin errors++; $display("FAIL orphan_rready got %b exp 0", m_if.RDATA_ready); end
    @(negedge CLK);
    m_if.RDATA = '0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
    @(negedge CLK); #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    r0_if.ARADDR = {1'b1, 32'h4000}; m_if.ARADDR_ready = 1'b1; r0_if.RDATA_ready = 1'b1;
    @(negedge CLK);
    m_if.RDATA = {1'b1, 64'h5}; m_if.RLAST = 1'b0;
    #1;
    checks++; if (r0_if.RDATA[64] !== 1'b1) begin errors++; $display("FAIL midburst_valid got %b exp 1", r0_if.RDATA[64]); end
    #1 reset = 1'b1;
    #1;
    checks++; if (r0_if.RDATA[64] !== 1'b0) begin errors++; $display("FAIL async_r0_valid got %b exp 0", r0_if.RDATA[64]); end
    checks++; if (m_if.RDATA_ready !== 1'b0) begin errors++; $display("FAIL async_rready got %b exp 0", m_if.RDATA_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL async_outstanding got %0d exp 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL async_err got %b exp 0", err_orphan); end
    checks++; if (m_if.ARADDR !== 33'h0) begin errors++; $display("FAIL async_araddr got %h exp 0", m_if.ARADDR); end
    checks++; if (r0_if.ARADDR_ready !== 1'b0) begin errors++; $display("FAIL async_r0_ready got %b exp 0", r0_if.ARADDR_ready); end
    idle();
    @(negedge CLK) reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_ar_stall();
    test_rr_fill();
    test_r_steer();
    test_full_pop_push();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
